// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Byte-stream boot loader that writes a framed program image into the
//   writable instruction RAM. It keeps the core in reset until a frame has
//   been loaded and its checksum has matched.
//
//   Frame layout: LEN_LO, LEN_HI (word count N), 4*N data bytes (each word
//   least-significant byte first), then CHK, the XOR of the data bytes.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous reset, active low
//   start       one-cycle load request (honoured in IDLE/DONE/ERR)
//   byte_valid  byte_data holds a valid byte
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   mem_we      one-cycle instruction RAM write strobe
//   mem_addr    byte address of the write (word aligned)
//   mem_wdata   instruction word to write
//   cpu_rst_n   core reset, active low; high only in DONE
//   busy        high while receiving a frame (LEN0/LEN1/DATA/CHECK)
//   done        high in DONE
//   error       high in ERR
module instr_mem_loader #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // idx must be able to count up to DEPTH_WORDS itself.
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [31:0]        word_q, word_d;
  logic [7:0]         chk_q, chk_d;
  logic               mem_we_q, mem_we_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               receiving;
  logic               xfer;

  assign receiving  = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CHECK);
  assign byte_ready = receiving;
  assign busy       = receiving;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign xfer       = byte_valid && receiving;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN0;
          idx_d   = '0;
          bcnt_d  = '0;
          chk_d   = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = byte_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = byte_data;
          if ({byte_data, len_q[7:0]} > 16'(DEPTH_WORDS)) begin
            state_d = S_ERR;
          end else if ({byte_data, len_q[7:0]} == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          chk_d                  = chk_q ^ byte_data;
          word_d[8*bcnt_q +: 8]  = byte_data;
          bcnt_d                 = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Word complete: the write strobe appears in the following cycle.
            mem_we_d    = 1'b1;
            mem_addr_d  = WIDTH'(BASE_ADDR) + WIDTH'({idx_q, 2'b00});
            mem_wdata_d = word_d;
            idx_d       = idx_q + IDX_W'(1);
            if (16'(idx_q) + 16'd1 == len_q) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          state_d = (byte_data == chk_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so the core leaves reset on the edge that enters DONE.
    cpu_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader (default parameters: WIDTH=32,
//   DEPTH_WORDS=64, BASE_ADDR=0). A negedge monitor records every RAM write.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  tx[$];

  instr_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Optional gaps of 0..3 idle cycles, with random start pulses inside them.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        start = ($urandom_range(0, 1) == 1);
        tick();
        start = 1'b0;
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout: observed=0 expected=1");
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_tx(input bit gaps);
    foreach (tx[i]) send_byte(tx[i], gaps);
  endtask

  task automatic clear_writes();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_frame1(input string t);
    check({t, "_nwr"},  wa.size(), 2);
    check({t, "_a0"},   wa[0], 32'h0000_0000);
    check({t, "_d0"},   wd[0], 32'h00C0_0413);
    check({t, "_a1"},   wa[1], 32'h0000_0004);
    check({t, "_d1"},   wd[1], 32'h0090_0493);
    check({t, "_done"}, done, 1'b1);
    check({t, "_crst"}, cpu_rst_n, 1'b1);
    check({t, "_err"},  error, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  ck;

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    tick();
    tick();

    // Reset state
    check("rst_ready", byte_ready, 1'b0);
    check("rst_we",    mem_we,     1'b0);
    check("rst_addr",  mem_addr,   32'h0);
    check("rst_wdata", mem_wdata,  32'h0);
    check("rst_crst",  cpu_rst_n,  1'b0);
    check("rst_busy",  busy,       1'b0);
    check("rst_done",  done,       1'b0);
    check("rst_err",   error,      1'b0);
    rst_n = 1'b1;
    tick();

    // Test 1: two-word frame back to back
    clear_writes();
    pulse_start();
    check("t1_busy", busy, 1'b1);
    tx = '{8'h02, 8'h00, 8'h13, 8'h04, 8'hC0, 8'h00, 8'h93, 8'h04, 8'h90, 8'h00, 8'hD0};
    send_tx(1'b0);
    check_frame1("t1");
    check("t1_we_low",   mem_we,    1'b0);
    check("t1_addr_hold", mem_addr,  32'h4);
    check("t1_data_hold", mem_wdata, 32'h0090_0493);
    check("t1_ready",    byte_ready, 1'b0);

    // Test 2: bad checksum, then reload from ERR
    clear_writes();
    pulse_start();
    check("t2_crst_fall", cpu_rst_n, 1'b0);
    tx = '{8'h02, 8'h00, 8'h13, 8'h04, 8'hC0, 8'h00, 8'h93, 8'h04, 8'h90, 8'h00, 8'hD1};
    send_tx(1'b0);
    check("t2_nwr",  wa.size(), 2);
    check("t2_err",  error,     1'b1);
    check("t2_crst", cpu_rst_n, 1'b0);
    check("t2_done", done,      1'b0);
    repeat (3) tick();
    check("t2_err_hold", error, 1'b1);
    clear_writes();
    pulse_start();
    tx = '{8'h02, 8'h00, 8'h13, 8'h04, 8'hC0, 8'h00, 8'h93, 8'h04, 8'h90, 8'h00, 8'hD0};
    send_tx(1'b0);
    check_frame1("t2r");

    // Test 3: length 0x41 exceeds capacity
    clear_writes();
    pulse_start();
    tx = '{8'h41, 8'h00};
    send_tx(1'b0);
    check("t3_err",   error,      1'b1);
    check("t3_ready", byte_ready, 1'b0);
    check("t3_nwr",   wa.size(),  0);
    check("t3_crst",  cpu_rst_n,  1'b0);

    // Test 4: empty image, good and bad checksum
    clear_writes();
    pulse_start();
    tx = '{8'h00, 8'h00, 8'h00};
    send_tx(1'b0);
    check("t4_done", done,      1'b1);
    check("t4_nwr",  wa.size(), 0);
    pulse_start();
    tx = '{8'h00, 8'h00, 8'h01};
    send_tx(1'b0);
    check("t4_err",  error,     1'b1);
    check("t4_done_b", done,    1'b0);

    // Test 5: random gaps and ignored start pulses
    clear_writes();
    pulse_start();
    tx = '{8'h02, 8'h00, 8'h13, 8'h04, 8'hC0, 8'h00, 8'h93, 8'h04, 8'h90, 8'h00, 8'hD0};
    send_tx(1'b1);
    check_frame1("t5");

    // Full-capacity image: 64 words, exactly at the length limit
    clear_writes();
    pulse_start();
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    ck = 8'h00;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), 8'(i) ^ 8'h5A, 8'hC3, 8'(i + 1)};
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], 1'b0);
        ck = ck ^ w[8*k +: 8];
      end
    end
    send_byte(ck, 1'b0);
    check("t64_nwr",  wa.size(), 64);
    check("t64_a63",  wa[63], 32'h0000_00FC);
    check("t64_d63",  wd[63], 32'h3F65_C340);
    check("t64_d0",   wd[0],  32'h005A_C301);
    check("t64_done", done,   1'b1);

    // Test 6: reset mid-frame after the 5th data byte
    clear_writes();
    pulse_start();
    tx = '{8'h02, 8'h00, 8'h13, 8'h04, 8'hC0, 8'h00, 8'h93};
    send_tx(1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_we",    mem_we,     1'b0);
    check("t6_addr",  mem_addr,   32'h0);
    check("t6_wdata", mem_wdata,  32'h0);
    check("t6_crst",  cpu_rst_n,  1'b0);
    check("t6_busy",  busy,       1'b0);
    check("t6_ready", byte_ready, 1'b0);
    clear_writes();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (5) tick();
    byte_valid = 1'b0;
    check("t6_ign_busy", busy,      1'b0);
    check("t6_ign_done", done,      1'b0);
    check("t6_ign_nwr",  wa.size(), 0);
    pulse_start();
    tx = '{8'h02, 8'h00, 8'h13, 8'h04, 8'hC0, 8'h00, 8'h93, 8'h04, 8'h90, 8'h00, 8'hD0};
    send_tx(1'b0);
    check_frame1("t6r");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
